// File: rtl/gobou_serial_vec.sv
// Output serializer for the gobou FC engine: captures one word per core on a
// load pulse and drains them lane 0 first, one per cycle, with optional ReLU.
module gobou_serial_vec #(
  parameter int CORE   = 16,
  parameter int DWIDTH = 16,
  parameter int CNTW   = 5
) (
  input  logic                     clk,
  input  logic                     xrst,
  input  logic                     serial_we,
  input  logic                     relu_en,
  input  logic [CORE*DWIDTH-1:0]   in_data,
  output logic                     out_valid,
  output logic signed [DWIDTH-1:0] out_data,
  output logic [CNTW-1:0]          out_idx,
  output logic                     busy,
  output logic                     overrun
);

  localparam logic [CNTW-1:0] LAST = CNTW'(CORE);

  // cnt==0 is idle; cnt==k (1..CORE) is presenting lane k-1
  logic [CNTW-1:0]          cnt;
  logic [CORE*DWIDTH-1:0]   shreg;
  logic                     relu_q;
  logic                     ovr_q;
  logic                     draining;
  logic [DWIDTH-1:0]        lane0;

  assign draining = (cnt != '0);
  assign lane0    = shreg[DWIDTH-1:0];

  always_ff @(posedge clk) begin
    if (xrst) begin
      cnt    <= '0;
      shreg  <= '0;
      relu_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else if (serial_we) begin
      shreg  <= in_data;
      relu_q <= relu_en;
      cnt    <= CNTW'(1);
      // reloading on the final drain cycle loses nothing, so no overrun then
      ovr_q  <= draining && (cnt != LAST);
    end else begin
      ovr_q <= 1'b0;
      if (draining) begin
        shreg <= shreg >> DWIDTH;
        cnt   <= (cnt == LAST) ? '0 : cnt + 1'b1;
      end
    end
  end

  always_comb begin
    out_valid = draining;
    busy      = draining;
    overrun   = ovr_q;
    out_data  = '0;
    out_idx   = '0;
    if (draining) begin
      out_idx  = cnt - 1'b1;
      out_data = (relu_q && lane0[DWIDTH-1]) ? '0 : $signed(lane0);
    end
  end

endmodule

// File: tb/tb_gobou_serial_vec.sv
// Self-checking bench: a CORE=4 instance against a queue-based expected-word
// model, plus a default-parameter instance for the 16-lane ramp case.
module tb_gobou_serial_vec;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // CORE=4 instance
  logic        xrst, serial_we, relu_en;
  logic [63:0] in_data;
  logic        out_valid, busy, overrun;
  logic signed [15:0] out_data;
  logic [4:0]  out_idx;

  gobou_serial_vec #(.CORE(4), .DWIDTH(16), .CNTW(5)) dut4 (
    .clk(clk), .xrst(xrst), .serial_we(serial_we), .relu_en(relu_en),
    .in_data(in_data), .out_valid(out_valid), .out_data(out_data),
    .out_idx(out_idx), .busy(busy), .overrun(overrun)
  );

  // default-parameter instance
  logic         xrst16, we16, relu16;
  logic [255:0] in16;
  logic         valid16, busy16, ovr16;
  logic signed [15:0] data16;
  logic [4:0]   idx16;

  gobou_serial_vec dut16 (
    .clk(clk), .xrst(xrst16), .serial_we(we16), .relu_en(relu16),
    .in_data(in16), .out_valid(valid16), .out_data(data16),
    .out_idx(idx16), .busy(busy16), .overrun(ovr16)
  );

  typedef struct {
    logic [15:0] data;
    logic [4:0]  idx;
  } exp_t;

  exp_t q[$];
  bit   exp_ovr;
  int   n_total = 0;
  int   n_pass  = 0;

  function automatic logic [63:0] pack4(input int a, input int b, input int c, input int d);
    logic [15:0] l0, l1, l2, l3;
    l0 = 16'(a); l1 = 16'(b); l2 = 16'(c); l3 = 16'(d);
    return {l3, l2, l1, l0};
  endfunction

  // Checks the current cycle's outputs against the model, then drives the
  // inputs for this cycle and advances the model across the coming edge.
  task automatic step(input bit rst, input bit we, input bit relu, input logic [63:0] vec,
                      input string tag);
    logic [15:0] ed;
    logic [4:0]  ei;
    bit          ev;
    logic signed [15:0] x;
    @(negedge clk);
    ev = (q.size() != 0);
    ed = ev ? q[0].data : 16'd0;
    ei = ev ? q[0].idx  : 5'd0;
    n_total++;
    if (out_valid !== ev || busy !== ev)
      $display("FAIL %s valid: got %b/%b want %b", tag, out_valid, busy, ev);
    else n_pass++;
    n_total++;
    if (out_data !== ed) $display("FAIL %s data: got %0d want %0d", tag, out_data, $signed(ed));
    else n_pass++;
    n_total++;
    if (out_idx !== ei) $display("FAIL %s idx: got %0d want %0d", tag, out_idx, ei);
    else n_pass++;
    n_total++;
    if (overrun !== exp_ovr) $display("FAIL %s overrun: got %b want %b", tag, overrun, exp_ovr);
    else n_pass++;

    xrst = rst; serial_we = we; relu_en = relu; in_data = vec;
    if (ev) void'(q.pop_front());
    if (rst) begin
      q.delete();
      exp_ovr = 0;
    end else if (we) begin
      exp_ovr = (q.size() != 0);
      q.delete();
      for (int i = 0; i < 4; i++) begin
        exp_t e;
        x = $signed(vec[i*16 +: 16]);
        e.data = (relu && x < 0) ? 16'd0 : x;
        e.idx  = 5'(i);
        q.push_back(e);
      end
    end else begin
      exp_ovr = 0;
    end
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) step(0, 0, 0, 64'($urandom()) << 32 | 64'($urandom()), tag);
  endtask

  task automatic test_reset();
    xrst = 1; serial_we = 1; relu_en = 1; in_data = '1;
    xrst16 = 1; we16 = 0; relu16 = 0; in16 = '0;
    repeat (3) @(posedge clk);
    q.delete(); exp_ovr = 0;
    step(1, 1, 0, pack4(1, 2, 3, 4), "reset_prio");
    step(0, 0, 0, '0, "reset_hold");
    idle(2, "reset_state");
  endtask

  task automatic test_basic();
    step(0, 1, 0, pack4(5, -3, 7, 32'h7FFF), "basic_load");
    idle(6, "basic_drain");
  endtask

  task automatic test_relu();
    step(0, 1, 1, pack4(5, -3, 7, 32'h7FFF), "relu_load");
    idle(5, "relu_drain");
    step(0, 1, 1, pack4(32'h8000, -1, 2, -32767), "relu_neg_load");
    idle(5, "relu_neg_drain");
  endtask

  task automatic test_back_to_back();
    step(0, 1, 0, pack4(5, -3, 7, 32'h7FFF), "b2b_load1");
    idle(3, "b2b_drain1");
    step(0, 1, 0, pack4(1, 2, 3, 4), "b2b_load2");
    idle(5, "b2b_drain2");
  endtask

  task automatic test_overrun();
    step(0, 1, 0, pack4(5, -3, 7, 32'h7FFF), "ovr_load1");
    idle(1, "ovr_drain1");
    step(0, 1, 0, pack4(9, 9, 9, 9), "ovr_load2");
    idle(6, "ovr_drain2");
  endtask

  task automatic test_hold();
    for (int i = 0; i < 3; i++)
      step(0, 1, i[0], {$urandom(), $urandom()}, "hold_load");
    idle(6, "hold_drain");
  endtask

  task automatic test_reset_mid();
    step(0, 1, 0, pack4(5, -3, 7, 32'h7FFF), "rstmid_load");
    idle(1, "rstmid_drain");
    step(1, 0, 0, '0, "rstmid_rst");
    idle(2, "rstmid_after");
    step(0, 1, 0, pack4(11, 12, 13, 14), "rstmid_reload");
    idle(5, "rstmid_drain2");
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      bit rst, we;
      rst = ($urandom_range(0, 39) == 0);
      we  = ($urandom_range(0, 3) == 0);
      step(rst, we, 1'($urandom()), {$urandom(), $urandom()}, "random");
    end
    idle(6, "random_tail");
  endtask

  task automatic test_ramp16();
    logic signed [15:0] ramp;
    @(negedge clk);
    xrst16 = 0; we16 = 1; relu16 = 1;
    for (int i = 0; i < 16; i++) begin
      ramp = 16'(i - 8);
      in16[i*16 +: 16] = ramp;
    end
    @(negedge clk);
    we16 = 0; in16 = '0;
    for (int i = 0; i < 16; i++) begin
      int want;
      want = (i < 8) ? 0 : i - 8;
      n_total++;
      if (valid16 !== 1'b1 || data16 !== 16'(want) || idx16 !== 5'(i) || ovr16 !== 1'b0)
        $display("FAIL ramp16 lane %0d: got v=%b d=%0d i=%0d o=%b want v=1 d=%0d i=%0d o=0",
                 i, valid16, data16, idx16, ovr16, want, i);
      else n_pass++;
      @(negedge clk);
    end
    n_total++;
    if (valid16 !== 1'b0 || data16 !== 16'sd0 || idx16 !== 5'd0)
      $display("FAIL ramp16 end: got v=%b d=%0d i=%0d want v=0 d=0 i=0", valid16, data16, idx16);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_relu();
    test_back_to_back();
    test_overrun();
    test_hold();
    test_reset_mid();
    test_random();
    test_ramp16();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
